// File: rtl/wb_ctrl_if.sv
// Writeback controller bus: ALU/LSU result channels, issue/decode lookups,
// register-file write port and bypass outputs.
interface wb_ctrl_if #(
  parameter int XLEN = 32
);
  logic            alu_valid;
  logic            alu_ready;
  logic [4:0]      alu_rd;
  logic [XLEN-1:0] alu_data;
  logic            lsu_valid;
  logic            lsu_ready;
  logic [4:0]      lsu_rd;
  logic [XLEN-1:0] lsu_data;
  logic            issue_valid;
  logic [4:0]      issue_rd;
  logic [4:0]      ra1;
  logic [4:0]      ra2;
  logic            rs1_busy;
  logic            rs2_busy;
  logic            we;
  logic [4:0]      wa;
  logic [XLEN-1:0] wd;
  logic            byp1_hit;
  logic            byp2_hit;
  logic [XLEN-1:0] byp_data;

  // Master side: execute/memory/decode driving the controller.
  modport master (
    output alu_valid, alu_rd, alu_data,
    output lsu_valid, lsu_rd, lsu_data,
    output issue_valid, issue_rd, ra1, ra2,
    input  alu_ready, lsu_ready, rs1_busy, rs2_busy,
    input  we, wa, wd, byp1_hit, byp2_hit, byp_data
  );

  modport slave (
    input  alu_valid, alu_rd, alu_data,
    input  lsu_valid, lsu_rd, lsu_data,
    input  issue_valid, issue_rd, ra1, ra2,
    output alu_ready, lsu_ready, rs1_busy, rs2_busy,
    output we, wa, wd, byp1_hit, byp2_hit, byp_data
  );
endinterface

// File: rtl/wb_ctrl.sv
// Writeback controller: LSU-over-ALU arbitration, one registered write per
// cycle, and a register busy scoreboard. Optional bypass: WB_BYPASS_EN.
module wb_ctrl #(
  parameter int XLEN = 32,
  parameter int NREG = 32
) (
  input logic       clk,
  input logic       reset,
  wb_ctrl_if.slave  bus
);
  logic            lsu_fire;
  logic            alu_fire;
  logic            we_q;
  logic [4:0]      wa_q;
  logic [XLEN-1:0] wd_q;
  logic [NREG-1:0] busy;
  logic [NREG-1:0] busy_nxt;
  logic [NREG-1:0] set_vec;
  logic [NREG-1:0] clr_vec;
  logic            clr_en;
  logic [4:0]      clr_a;

  assign bus.lsu_ready = !reset;
  assign bus.alu_ready = !reset && !bus.lsu_valid;
  assign lsu_fire      = bus.lsu_valid && bus.lsu_ready;
  assign alu_fire      = bus.alu_valid && bus.alu_ready;

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      we_q <= 1'b0;
      wa_q <= '0;
      wd_q <= '0;
    end else if (lsu_fire) begin
      we_q <= (bus.lsu_rd != 5'd0);
      wa_q <= bus.lsu_rd;
      wd_q <= bus.lsu_data;
    end else if (alu_fire) begin
      we_q <= (bus.alu_rd != 5'd0);
      wa_q <= bus.alu_rd;
      wd_q <= bus.alu_data;
    end else begin
      we_q <= 1'b0;
    end
  end

`ifdef WB_BYPASS_EN
  // Bypass covers the write cycle, so the bit can clear on the write itself.
  assign clr_en = we_q;
  assign clr_a  = wa_q;
`else
  logic       clr_q;
  logic [4:0] clr_aq;

  // Clear one cycle late so the synchronous RAM read sees the new value.
  // A reissue of the same register during the write cycle cancels the clear.
  always_ff @(posedge clk) begin
    if (reset) begin
      clr_q  <= 1'b0;
      clr_aq <= '0;
    end else begin
      clr_q  <= we_q && !(bus.issue_valid && bus.issue_rd == wa_q);
      clr_aq <= wa_q;
    end
  end

  assign clr_en = clr_q;
  assign clr_a  = clr_aq;
`endif

  // NOTE: every always_comb output gets a default first, so no latch is inferred.
  always_comb begin
    set_vec = '0;
    clr_vec = '0;
    if (bus.issue_valid && bus.issue_rd != 5'd0) set_vec[bus.issue_rd] = 1'b1;
    if (clr_en) clr_vec[clr_a] = 1'b1;
    // Set is applied after clear so a reissue wins.
    busy_nxt = (busy & ~clr_vec) | set_vec;
  end

  always_ff @(posedge clk) begin
    if (reset) busy <= '0;
    else       busy <= busy_nxt;
  end

  assign bus.we = we_q;
  assign bus.wa = wa_q;
  assign bus.wd = wd_q;

  // busy[0] is never set, so ra==0 always reads as not busy.
  always_comb begin
    bus.byp1_hit = 1'b0;
    bus.byp2_hit = 1'b0;
    bus.byp_data = '0;
`ifdef WB_BYPASS_EN
    bus.byp1_hit = we_q && (wa_q == bus.ra1) && (bus.ra1 != 5'd0);
    bus.byp2_hit = we_q && (wa_q == bus.ra2) && (bus.ra2 != 5'd0);
    bus.byp_data = wd_q;
`endif
    bus.rs1_busy = busy[bus.ra1] && !bus.byp1_hit;
    bus.rs2_busy = busy[bus.ra2] && !bus.byp2_hit;
  end
endmodule
